// File: rtl/raster_block_walker.sv
// Walks a primitive's bounding box in BLOCK_SIZE steps, row-major, and streams
// one block location per beat with the primitive's edges and id attached.
module raster_block_walker #(
  parameter int DIM_BITS      = 16,
  parameter int DATA_BITS     = 32,
  parameter int BLOCK_LOGSIZE = 2,
  parameter int PID_BITS      = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIM_BITS-1:0]    in_xmin,
  input  logic [DIM_BITS-1:0]    in_xmax,
  input  logic [DIM_BITS-1:0]    in_ymin,
  input  logic [DIM_BITS-1:0]    in_ymax,
  input  logic [9*DATA_BITS-1:0] in_edges,
  input  logic [PID_BITS-1:0]    in_pid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIM_BITS-1:0]    out_xloc,
  output logic [DIM_BITS-1:0]    out_yloc,
  output logic [9*DATA_BITS-1:0] out_edges,
  output logic [PID_BITS-1:0]    out_pid,
  output logic                   out_last
);

  localparam int                  BS         = 1 << BLOCK_LOGSIZE;
  localparam logic [DIM_BITS:0]   BS_W       = (DIM_BITS+1)'(BS);
  localparam logic [DIM_BITS-1:0] BS_N       = DIM_BITS'(BS);
  localparam logic [DIM_BITS-1:0] ALIGN_MASK = ~DIM_BITS'(BS - 1);

  typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_e;

  state_e                 state_q;
  logic [DIM_BITS-1:0]    x_q, y_q, xs_q, xmax_q, ymax_q;
  logic [9*DATA_BITS-1:0] edges_q;
  logic [PID_BITS-1:0]    pid_q;
  logic                   valid_q, last_q;

  logic [DIM_BITS-1:0]    xs_a, ys_a, x_d, y_d, xlim, ylim;
  logic [DIM_BITS:0]      nx;
  logic                   empty, last_d;

  // Next block position: the aligned start when accepting, otherwise the
  // successor of the current block. The row step cannot wrap because it only
  // happens on a non-last block, which implies y+BS < ymax.
  always_comb begin
    xs_a  = in_xmin & ALIGN_MASK;
    ys_a  = in_ymin & ALIGN_MASK;
    empty = (in_xmax <= in_xmin) || (in_ymax <= in_ymin);
    nx    = {1'b0, x_q} + BS_W;
    if (state_q == IDLE) begin
      x_d  = xs_a;
      y_d  = ys_a;
      xlim = in_xmax;
      ylim = in_ymax;
    end else begin
      xlim = xmax_q;
      ylim = ymax_q;
      if (nx < {1'b0, xmax_q}) begin
        x_d = nx[DIM_BITS-1:0];
        y_d = y_q;
      end else begin
        x_d = xs_q;
        y_d = y_q + BS_N;
      end
    end
    last_d = (({1'b0, x_d} + BS_W) >= {1'b0, xlim}) &&
             (({1'b0, y_d} + BS_W) >= {1'b0, ylim});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      edges_q <= '0;
      pid_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            edges_q <= in_edges;
            pid_q   <= in_pid;
            xmax_q  <= in_xmax;
            ymax_q  <= in_ymax;
            xs_q    <= xs_a;
            if (empty) begin
              state_q <= DRAIN;
            end else begin
              state_q <= WALK;
              valid_q <= 1'b1;
              x_q     <= x_d;
              y_q     <= y_d;
              last_q  <= last_d;
            end
          end
        end
        WALK: begin
          if (out_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              last_q <= last_d;
            end
          end
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_xloc  = x_q;
  assign out_yloc  = y_q;
  assign out_edges = edges_q;
  assign out_pid   = pid_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_raster_block_walker.sv
// Self-checking bench for raster_block_walker: directed cases plus random
// descriptors, compared against a loop-based model of the block walk order.
module tb_raster_block_walker;

  localparam int DIM_BITS  = 16;
  localparam int DATA_BITS = 32;
  localparam int PID_BITS  = 8;
  localparam int EW        = 9 * DATA_BITS;

  typedef struct {
    logic [DIM_BITS-1:0] xmin, xmax, ymin, ymax;
    logic [EW-1:0]       edges;
    logic [PID_BITS-1:0] pid;
  } desc_t;

  typedef struct {
    logic [DIM_BITS-1:0] x, y;
    logic                last;
    logic [EW-1:0]       edges;
    logic [PID_BITS-1:0] pid;
  } beat_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_valid, in_ready;
  logic [DIM_BITS-1:0] in_xmin, in_xmax, in_ymin, in_ymax;
  logic [EW-1:0]       in_edges;
  logic [PID_BITS-1:0] in_pid;
  logic                out_valid, out_ready, out_last;
  logic [DIM_BITS-1:0] out_xloc, out_yloc;
  logic [EW-1:0]       out_edges;
  logic [PID_BITS-1:0] out_pid;

  raster_block_walker dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_xmin(in_xmin), .in_xmax(in_xmax), .in_ymin(in_ymin), .in_ymax(in_ymax),
    .in_edges(in_edges), .in_pid(in_pid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xloc(out_xloc), .out_yloc(out_yloc),
    .out_edges(out_edges), .out_pid(out_pid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int    errCount = 0;
  int    checkCount = 0;
  int    popCount = 0;
  int    readyPct = 100;
  bit    mIdle = 1'b1;
  bit    mDrain = 1'b0;
  bit    havePending = 1'b0;
  desc_t pend;
  desc_t descQ[$];
  beat_t expQ[$];
  bit    readyQ[$];

  task automatic checkOutput(input string tag, input logic [EW-1:0] actual, input logic [EW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected beats straight from the bbox: rows from aligned ys, columns from aligned xs.
  task automatic buildBeats(input desc_t d, output int n);
    int xs, ys;
    beat_t b;
    n = 0;
    if (d.xmax <= d.xmin || d.ymax <= d.ymin) return;
    xs = int'(d.xmin) / 4 * 4;
    ys = int'(d.ymin) / 4 * 4;
    for (int y = ys; y < int'(d.ymax); y += 4)
      for (int x = xs; x < int'(d.xmax); x += 4) begin
        b.x = DIM_BITS'(x);
        b.y = DIM_BITS'(y);
        b.last = (x + 4 >= int'(d.xmax)) && (y + 4 >= int'(d.ymax));
        b.edges = d.edges;
        b.pid = d.pid;
        expQ.push_back(b);
        n++;
      end
  endtask

  // One cycle: check at negedge, drive inputs, then advance the model past the next posedge.
  task automatic applyStimulus();
    bit    curIdle, accept;
    int    n;
    beat_t b;
    @(negedge clk);
    checkOutput("in_ready", EW'(in_ready), EW'(mIdle));
    checkOutput("out_valid", EW'(out_valid), EW'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      b = expQ[0];
      checkOutput("out_xloc", EW'(out_xloc), EW'(b.x));
      checkOutput("out_yloc", EW'(out_yloc), EW'(b.y));
      checkOutput("out_last", EW'(out_last), EW'(b.last));
      checkOutput("out_pid", EW'(out_pid), EW'(b.pid));
      checkOutput("out_edges", out_edges, b.edges);
    end
    if (!havePending && descQ.size() != 0) begin
      pend = descQ.pop_front();
      havePending = 1'b1;
    end
    in_valid = havePending;
    in_xmin = pend.xmin; in_xmax = pend.xmax;
    in_ymin = pend.ymin; in_ymax = pend.ymax;
    in_edges = pend.edges; in_pid = pend.pid;
    if (readyQ.size() != 0) out_ready = readyQ.pop_front();
    else out_ready = ($urandom_range(0, 99) < readyPct);
    curIdle = mIdle;
    accept = curIdle && havePending;
    if (expQ.size() != 0 && out_ready) begin
      b = expQ.pop_front();
      popCount++;
      if (b.last) mIdle = 1'b1;
    end
    if (mDrain) begin
      mDrain = 1'b0;
      mIdle = 1'b1;
    end
    if (accept) begin
      havePending = 1'b0;
      buildBeats(pend, n);
      mIdle = 1'b0;
      if (n == 0) mDrain = 1'b1;
    end
  endtask

  task automatic runUntilIdle(input int budget);
    int cyc = 0;
    while ((descQ.size() != 0 || havePending || !mIdle || expQ.size() != 0) && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    if (cyc >= budget) checkOutput("timeout", 1, 0);
    applyStimulus();
  endtask

  function automatic desc_t mkDesc(input int x0, input int x1, input int y0, input int y1, input int pid);
    desc_t d;
    d.xmin = DIM_BITS'(x0); d.xmax = DIM_BITS'(x1);
    d.ymin = DIM_BITS'(y0); d.ymax = DIM_BITS'(y1);
    d.pid = PID_BITS'(pid);
    for (int i = 0; i < 9; i++) d.edges[i*DATA_BITS +: DATA_BITS] = $urandom;
    return d;
  endfunction

  task automatic checkResetState();
    checkOutput("rst_in_ready", EW'(in_ready), 1);
    checkOutput("rst_out_valid", EW'(out_valid), 0);
    checkOutput("rst_out_last", EW'(out_last), 0);
    checkOutput("rst_out_xloc", EW'(out_xloc), 0);
    checkOutput("rst_out_yloc", EW'(out_yloc), 0);
    checkOutput("rst_out_pid", EW'(out_pid), 0);
    checkOutput("rst_out_edges", out_edges, 0);
  endtask

  initial begin
    desc_t d;
    int    cyc;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_xmin = '0; in_xmax = '0; in_ymin = '0; in_ymax = '0; in_edges = '0; in_pid = '0;
    pend = mkDesc(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkResetState();
    reset_n = 1'b1;

    d = mkDesc(0, 8, 0, 8, 5);
    for (int i = 0; i < 9; i++) d.edges[i*DATA_BITS +: DATA_BITS] = DATA_BITS'(i + 1);
    descQ.push_back(d);
    runUntilIdle(50);

    descQ.push_back(mkDesc(0, 8, 0, 8, 6));
    readyQ = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    runUntilIdle(50);

    descQ.push_back(mkDesc(8, 8, 0, 8, 7));
    descQ.push_back(mkDesc(5, 10, 6, 7, 8));
    descQ.push_back(mkDesc(16'hFFF8, 16'hFFFF, 0, 4, 9));
    runUntilIdle(100);

    // Reset mid-walk, asserted between clock edges after the third beat.
    popCount = 0;
    descQ.push_back(mkDesc(0, 16, 0, 16, 10));
    cyc = 0;
    while (popCount < 3 && cyc < 50) begin
      applyStimulus();
      cyc++;
    end
    if (cyc >= 50) checkOutput("reset_timeout", 1, 0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("async_out_valid", EW'(out_valid), 0);
    checkOutput("async_in_ready", EW'(in_ready), 1);
    expQ.delete();
    descQ.delete();
    havePending = 1'b0;
    mIdle = 1'b1;
    mDrain = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    descQ.push_back(mkDesc(0, 4, 0, 4, 11));
    runUntilIdle(50);

    descQ.push_back(mkDesc(0, 12, 0, 8, 12));
    descQ.push_back(mkDesc(4, 9, 0, 5, 13));
    runUntilIdle(100);

    readyPct = 70;
    for (int i = 0; i < 40; i++) begin
      int x0, y0, x1, y1;
      if ($urandom_range(0, 7) == 0) begin
        x0 = $urandom_range(16'hFFE0, 16'hFFFF);
        x1 = x0 + $urandom_range(0, 20);
        if (x1 > 16'hFFFF) x1 = 16'hFFFF;
      end else begin
        x0 = $urandom_range(0, 40);
        x1 = x0 + $urandom_range(0, 14) - ($urandom_range(0, 9) == 0 ? 3 : 0);
        if (x1 < 0) x1 = 0;
      end
      y0 = $urandom_range(0, 40);
      y1 = y0 + $urandom_range(0, 14);
      descQ.push_back(mkDesc(x0, x1, y0, y1, $urandom_range(0, 255)));
    end
    runUntilIdle(4000);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
